// File: rtl/odu_pkg.sv
// Shared ODU framing constants: row headers, stuff pattern, MFAS tags, widths,
// deframer state encoding, plus small helpers used by generator and deframer.
package odu_pkg;

    localparam int SEG_W  = 128;
    localparam int BEAT_W = 384;
    localparam int ACC_W  = 640;

    localparam logic [127:0] HDR_ROW0  = {16{8'h11}};
    localparam logic [127:0] HDR_ROW1  = {16{8'h22}};
    localparam logic [127:0] HDR_ROW2  = {16{8'h33}};
    localparam logic [127:0] STUFF_PAT = {16{8'h99}};

    localparam logic [7:0] MFAS_ROW0 = 8'd0;
    localparam logic [7:0] MFAS_ROW1 = 8'd64;
    localparam logic [7:0] MFAS_ROW2 = 8'd128;

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_SYNC = 1'b1
    } dfr_state_e;

    function automatic logic [127:0] hdr_for_row(input logic [1:0] row);
        case (row)
            2'd0:    return HDR_ROW0;
            2'd1:    return HDR_ROW1;
            2'd2:    return HDR_ROW2;
            default: return HDR_ROW0;
        endcase
    endfunction

    function automatic logic [7:0] mfas_for_row(input logic [1:0] row);
        case (row)
            2'd0:    return MFAS_ROW0;
            2'd1:    return MFAS_ROW1;
            2'd2:    return MFAS_ROW2;
            default: return MFAS_ROW0;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/odu_deframer_osu_gearbox.sv
// Segment gearbox: appends 0/2/3 incoming 128-bit segments behind a residue of
// 0..2 segments and emits the oldest three as one 384-bit packet when available.
module osu_gearbox
    import odu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_seg_cnt,
    input  logic [BEAT_W-1:0] i_seg_bus,
    input  logic              i_flush,
    output logic [BEAT_W-1:0] o_pkt,
    output logic              o_pkt_valid
);

    logic [ACC_W-1:0]  acc_q, acc_d, merged_s;
    logic [BEAT_W-1:0] bus_s;
    logic [2:0]        fill_q, fill_d, total_s;

    // Mask off segment slots the producer did not declare valid
    always_comb begin
        case (i_seg_cnt)
            2'd3:    bus_s = i_seg_bus;
            2'd2:    bus_s = {i_seg_bus[BEAT_W-1:SEG_W], 128'd0};
            default: bus_s = 384'd0;
        endcase
    end

    // Place new segments directly behind the residue (oldest sits at the MSB end)
    always_comb begin
        case (fill_q)
            3'd0:    merged_s = acc_q | {bus_s, 256'd0};
            3'd1:    merged_s = acc_q | {128'd0, bus_s, 128'd0};
            3'd2:    merged_s = acc_q | {256'd0, bus_s};
            default: merged_s = acc_q;
        endcase
    end

    // Emit at most one packet per beat; flush discards everything including it
    always_comb begin
        total_s     = fill_q + {1'b0, i_seg_cnt};
        o_pkt       = merged_s[ACC_W-1:ACC_W-BEAT_W];
        o_pkt_valid = 1'b0;
        acc_d       = merged_s;
        fill_d      = total_s;
        if (i_flush) begin
            acc_d  = 640'd0;
            fill_d = 3'd0;
        end else if (total_s >= 3'd3) begin
            o_pkt_valid = 1'b1;
            acc_d       = {merged_s[ACC_W-BEAT_W-1:0], 384'd0};
            fill_d      = total_s - 3'd3;
        end else begin
            o_pkt_valid = 1'b0;
        end
    end

    // Accumulator and fill count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q  <= 640'd0;
            fill_q <= 3'd0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/odu_deframer.sv
// ODU row-stream deframer: locks on the 3-row multiframe, checks header and
// stuff fields, strips them and re-packs payload into 384-bit OSU packets.
module odu_deframer
    import odu_pkg::*;
#(
    parameter int ROW_BEATS = 80
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [BEAT_W-1:0] i_odu_data,
    input  logic              i_odu_valid,
    input  logic              i_odu_rs,
    input  logic [7:0]        i_odu_mfas,
    output logic [BEAT_W-1:0] o_osu_data,
    output logic              o_osu_valid,
    output logic              o_osu_first,
    output logic              o_locked,
    output logic [1:0]        o_row_idx,
    output logic [15:0]       o_hdr_err_cnt,
    output logic [15:0]       o_stuff_err_cnt
);

    localparam logic [6:0] LAST_BEAT = 7'(ROW_BEATS - 1);

    dfr_state_e        state_q, state_d;
    logic [6:0]        beat_cnt_q, beat_cnt_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [15:0]       hdr_err_q, hdr_err_d, stuff_err_q, stuff_err_d;
    logic              first_pend_q, first_pend_d;
    logic [BEAT_W-1:0] osu_data_q, osu_data_d;
    logic              osu_valid_q, osu_valid_d, osu_first_q, osu_first_d;

    logic [1:0]        exp_row_s;
    logic              lock_ok_s, hdr_err_s, stuff_err_s;
    logic [1:0]        seg_cnt_s;
    logic [BEAT_W-1:0] seg_bus_s, pkt_s;
    logic              flush_s, pkt_valid_s;

    // Header/stuff checks; a header beat is checked against the row it opens
    always_comb begin
        exp_row_s   = (row_idx_q == 2'd2) ? 2'd0 : row_idx_q + 2'd1;
        lock_ok_s   = i_odu_rs && (i_odu_mfas == MFAS_ROW0) && (i_odu_data[383:256] == HDR_ROW0);
        hdr_err_s   = 1'b0;
        stuff_err_s = 1'b0;
        if (i_odu_valid && (state_q == ST_SYNC)) begin
            if (beat_cnt_q == 7'd0) begin
                hdr_err_s = !i_odu_rs || (i_odu_mfas != mfas_for_row(exp_row_s))
                            || (i_odu_data[383:256] != hdr_for_row(exp_row_s));
            end else begin
                hdr_err_s   = i_odu_rs;
                stuff_err_s = !i_odu_rs && (beat_cnt_q == LAST_BEAT) && (i_odu_data[127:0] != STUFF_PAT);
            end
        end else begin
            hdr_err_s   = 1'b0;
            stuff_err_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (i_odu_valid) begin
            case (state_q)
                ST_HUNT: state_d = lock_ok_s ? ST_SYNC : ST_HUNT;
                ST_SYNC: state_d = hdr_err_s ? ST_HUNT : ST_SYNC;
                default: state_d = ST_HUNT;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: which segments of this beat feed the gearbox, or a flush
    always_comb begin
        seg_cnt_s = 2'd0;
        seg_bus_s = 384'd0;
        flush_s   = 1'b0;
        if (i_odu_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (lock_ok_s) begin
                        seg_cnt_s = 2'd2;
                        seg_bus_s = {i_odu_data[255:0], 128'd0};
                    end else begin
                        flush_s = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (hdr_err_s) begin
                        flush_s = 1'b1;
                    end else if (beat_cnt_q == 7'd0) begin
                        seg_cnt_s = 2'd2;
                        seg_bus_s = {i_odu_data[255:0], 128'd0};
                    end else if (beat_cnt_q == LAST_BEAT) begin
                        seg_cnt_s = 2'd2;
                        seg_bus_s = {i_odu_data[383:128], 128'd0};
                    end else begin
                        seg_cnt_s = 2'd3;
                        seg_bus_s = i_odu_data;
                    end
                end
                default: flush_s = 1'b1;
            endcase
        end else begin
            flush_s = 1'b0;
        end
    end

    osu_gearbox u_gearbox (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_seg_cnt   (seg_cnt_s),
        .i_seg_bus   (seg_bus_s),
        .i_flush     (flush_s),
        .o_pkt       (pkt_s),
        .o_pkt_valid (pkt_valid_s)
    );

    // Row tracking, error counters and multiframe-first marking
    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        row_idx_d    = row_idx_q;
        hdr_err_d    = hdr_err_q;
        stuff_err_d  = stuff_err_q;
        first_pend_d = first_pend_q;
        if (i_odu_valid) begin
            case (state_q)
                ST_HUNT: begin
                    beat_cnt_d   = lock_ok_s ? 7'd1 : 7'd0;
                    row_idx_d    = 2'd0;
                    first_pend_d = lock_ok_s;
                end
                ST_SYNC: begin
                    if (hdr_err_s) begin
                        beat_cnt_d   = 7'd0;
                        row_idx_d    = 2'd0;
                        first_pend_d = 1'b0;
                        hdr_err_d    = sat_inc16(hdr_err_q);
                    end else begin
                        beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? 7'd0 : beat_cnt_q + 7'd1;
                        if (pkt_valid_s) begin
                            first_pend_d = 1'b0;
                        end else begin
                            first_pend_d = first_pend_q;
                        end
                        if (beat_cnt_q == 7'd0) begin
                            row_idx_d = exp_row_s;
                            if (exp_row_s == 2'd0) begin
                                first_pend_d = 1'b1;
                            end else begin
                                first_pend_d = first_pend_q;
                            end
                        end else begin
                            row_idx_d = row_idx_q;
                        end
                        if (stuff_err_s) begin
                            stuff_err_d = sat_inc16(stuff_err_q);
                        end else begin
                            stuff_err_d = stuff_err_q;
                        end
                    end
                end
                default: begin
                    beat_cnt_d   = 7'd0;
                    row_idx_d    = 2'd0;
                    first_pend_d = 1'b0;
                end
            endcase
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
        osu_valid_d = pkt_valid_s;
        osu_first_d = pkt_valid_s && first_pend_q;
        osu_data_d  = pkt_valid_s ? pkt_s : osu_data_q;
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt_q   <= 7'd0;
            row_idx_q    <= 2'd0;
            hdr_err_q    <= 16'd0;
            stuff_err_q  <= 16'd0;
            first_pend_q <= 1'b0;
            osu_data_q   <= 384'd0;
            osu_valid_q  <= 1'b0;
            osu_first_q  <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            row_idx_q    <= row_idx_d;
            hdr_err_q    <= hdr_err_d;
            stuff_err_q  <= stuff_err_d;
            first_pend_q <= first_pend_d;
            osu_data_q   <= osu_data_d;
            osu_valid_q  <= osu_valid_d;
            osu_first_q  <= osu_first_d;
        end
    end

    assign o_osu_data      = osu_data_q;
    assign o_osu_valid     = osu_valid_q;
    assign o_osu_first     = osu_first_q;
    assign o_locked        = (state_q == ST_SYNC);
    assign o_row_idx       = row_idx_q;
    assign o_hdr_err_cnt   = hdr_err_q;
    assign o_stuff_err_cnt = stuff_err_q;

endmodule

// File: tb/tb_odu_deframer.sv
// Bench for odu_deframer: queue-based reference of lock/strip/repack behaviour,
// per-cycle comparison, plus literal packet-count and sequence expectations.
module tb_odu_deframer;

    localparam int R      = 80;
    localparam int PKT_MF = 238;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [383:0] i_odu_data = 384'd0;
    logic         i_odu_valid = 1'b0;
    logic         i_odu_rs = 1'b0;
    logic [7:0]   i_odu_mfas = 8'd0;
    logic [383:0] o_osu_data;
    logic         o_osu_valid, o_osu_first, o_locked;
    logic [1:0]   o_row_idx;
    logic [15:0]  o_hdr_err_cnt, o_stuff_err_cnt;

    odu_deframer #(.ROW_BEATS(R)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_odu_data(i_odu_data), .i_odu_valid(i_odu_valid),
        .i_odu_rs(i_odu_rs), .i_odu_mfas(i_odu_mfas), .o_osu_data(o_osu_data),
        .o_osu_valid(o_osu_valid), .o_osu_first(o_osu_first), .o_locked(o_locked),
        .o_row_idx(o_row_idx), .o_hdr_err_cnt(o_hdr_err_cnt), .o_stuff_err_cnt(o_stuff_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         valid;
        logic         first;
        logic         locked;
        logic [1:0]   row;
        logic [15:0]  hdr;
        logic [15:0]  stuff;
        logic [383:0] data;
    } exp_t;

    exp_t exp_nxt, exp_cur;
    int   n_checks = 0, n_fail = 0;
    int   pkt_total = 0, first_total = 0;
    bit   pin_en = 1'b0;
    int   pin_base = 0;
    logic [31:0] salt = 32'hC3A5_0F1E;

    // reference model state
    bit   m_locked;
    int   m_pos, m_row, m_hdr, m_stuff;
    bit   m_first_pend;
    logic [127:0] m_q[$];

    function automatic logic [127:0] seg(input int n);
        return {32'h5E60_0000 + 32'(n), 32'(n), ~32'(n), salt};
    endfunction

    function automatic logic [127:0] hdr_pat(input int r);
        logic [7:0] b;
        b = 8'(8'h11 * (r + 1));
        return {16{b}};
    endfunction

    function automatic logic [383:0] rnd384();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string nm, input logic [383:0] act, input logic [383:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_pos = 0; m_row = 0; m_hdr = 0; m_stuff = 0;
        m_first_pend = 1'b0;
        m_q.delete();
        exp_nxt = '0;
    endtask

    task automatic model_step(input logic v, input logic rs, input logic [7:0] mf, input logic [383:0] d);
        int nr;
        bit err;
        logic [127:0] a, b, c;
        exp_nxt.valid = 1'b0;
        exp_nxt.first = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (rs && mf == 8'd0 && d[383:256] == hdr_pat(0)) begin
                    m_locked = 1'b1; m_pos = 1; m_row = 0; m_first_pend = 1'b1;
                    m_q.delete();
                    m_q.push_back(d[255:128]);
                    m_q.push_back(d[127:0]);
                end
            end else begin
                nr = (m_row + 1) % 3;
                if (m_pos == 0) err = !rs || (mf != 8'(64 * nr)) || (d[383:256] != hdr_pat(nr));
                else            err = rs;
                if (err) begin
                    if (m_hdr < 65535) m_hdr++;
                    m_locked = 1'b0; m_pos = 0; m_row = 0; m_first_pend = 1'b0;
                    m_q.delete();
                end else begin
                    if (m_pos == 0) begin
                        m_row = nr;
                        if (nr == 0) m_first_pend = 1'b1;
                        m_q.push_back(d[255:128]);
                        m_q.push_back(d[127:0]);
                    end else if (m_pos == R - 1) begin
                        m_q.push_back(d[383:256]);
                        m_q.push_back(d[255:128]);
                        if (d[127:0] != {16{8'h99}} && m_stuff < 65535) m_stuff++;
                    end else begin
                        m_q.push_back(d[383:256]);
                        m_q.push_back(d[255:128]);
                        m_q.push_back(d[127:0]);
                    end
                    m_pos = (m_pos + 1) % R;
                    if (m_q.size() >= 3) begin
                        a = m_q.pop_front();
                        b = m_q.pop_front();
                        c = m_q.pop_front();
                        exp_nxt.valid = 1'b1;
                        exp_nxt.data  = {a, b, c};
                        exp_nxt.first = m_first_pend;
                        m_first_pend  = 1'b0;
                    end
                end
            end
        end
        exp_nxt.locked = m_locked;
        exp_nxt.row    = 2'(m_row);
        exp_nxt.hdr    = 16'(m_hdr);
        exp_nxt.stuff  = 16'(m_stuff);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  o_osu_data, 384'd0);
        check({tag, "_valid"}, 384'(o_osu_valid), 384'd0);
        check({tag, "_first"}, 384'(o_osu_first), 384'd0);
        check({tag, "_lock"},  384'(o_locked), 384'd0);
        check({tag, "_row"},   384'(o_row_idx), 384'd0);
        check({tag, "_hdr"},   384'(o_hdr_err_cnt), 384'd0);
        check({tag, "_stuff"}, 384'(o_stuff_err_cnt), 384'd0);
    endtask

    // one clock: latch expectation, drive beat, optional reset pulse, compare at negedge
    task automatic tick(input logic v, input logic rs, input logic [7:0] mf, input logic [383:0] d, input bit do_rst);
        int k;
        @(posedge clk);
        exp_cur = exp_nxt;
        #1;
        i_odu_valid = v; i_odu_rs = rs; i_odu_mfas = mf; i_odu_data = d;
        model_step(v, rs, mf, d);
        if (do_rst) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_all_zero("midrst");
            rst_n = 1'b1;
            model_reset();
            exp_cur = '0;
            model_step(v, rs, mf, d);
        end
        @(negedge clk);
        check("osu_valid", 384'(o_osu_valid), 384'(exp_cur.valid));
        if (exp_cur.valid) begin
            check("osu_data", o_osu_data, exp_cur.data);
            check("osu_first", 384'(o_osu_first), 384'(exp_cur.first));
        end
        check("locked", 384'(o_locked), 384'(exp_cur.locked));
        check("row_idx", 384'(o_row_idx), 384'(exp_cur.row));
        check("hdr_cnt", 384'(o_hdr_err_cnt), 384'(exp_cur.hdr));
        check("stuff_cnt", 384'(o_stuff_err_cnt), 384'(exp_cur.stuff));
        if (o_osu_valid) begin
            pkt_total++;
            if (o_osu_first) first_total++;
            if (pin_en) begin
                k = (pkt_total - 1 - pin_base) % PKT_MF;
                check("pin_seq", o_osu_data, {seg(3*k), seg(3*k+1), seg(3*k+2)});
                check("pin_first", 384'(o_osu_first), 384'(k == 0));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom), 8'($urandom), rnd384(), 1'b0);
    endtask

    task automatic send_mf(input int hb_row, input int sb_row, input int rs_row, input int rs_beat,
                           input int gap, input int rst_row, input int rst_beat);
        int n;
        logic [383:0] d;
        logic [127:0] h, st;
        n = 0;
        for (int row = 0; row < 3; row++) begin
            for (int b = 0; b < R; b++) begin
                while (int'($urandom_range(99)) < gap) idle(1);
                if (b == 0) begin
                    h = hdr_pat(row);
                    if (row == hb_row) h[47:40] = 8'h23;
                    d = {h, seg(n), seg(n+1)};
                    n += 2;
                end else if (b == R - 1) begin
                    st = (row == sb_row) ? {16{8'h98}} : {16{8'h99}};
                    d = {seg(n), seg(n+1), st};
                    n += 2;
                end else begin
                    d = {seg(n), seg(n+1), seg(n+2)};
                    n += 3;
                end
                tick(1'b1, (b == 0) || (row == rs_row && b == rs_beat), 8'(row * 64), d,
                     (row == rst_row) && (b == rst_beat));
            end
        end
    endtask

    initial begin
        int p0, f0;
        model_reset();
        exp_cur = '0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;

        // clean multiframe, literal sequence 0..713
        pin_en = 1'b1; pin_base = pkt_total; p0 = pkt_total; f0 = first_total;
        send_mf(-1, -1, -1, 0, 0, -1, 0);
        idle(2);
        check("clean_pkts", 384'(pkt_total - p0), 384'(PKT_MF));
        check("clean_first", 384'(first_total - f0), 384'd1);
        check("clean_lock", 384'(o_locked), 384'd1);
        check("clean_cnts", 384'({o_hdr_err_cnt, o_stuff_err_cnt}), 384'd0);

        // two multiframes with 50% valid gaps
        pin_base = pkt_total; p0 = pkt_total; f0 = first_total;
        send_mf(-1, -1, -1, 0, 50, -1, 0);
        send_mf(-1, -1, -1, 0, 50, -1, 0);
        idle(2);
        check("gap_pkts", 384'(pkt_total - p0), 384'(2 * PKT_MF));
        check("gap_first", 384'(first_total - f0), 384'd2);
        pin_en = 1'b0;

        // corrupted row-1 header
        p0 = pkt_total;
        send_mf(1, -1, -1, 0, 0, -1, 0);
        idle(2);
        check("hdrbad_cnt", 384'(o_hdr_err_cnt), 384'd1);
        check("hdrbad_lock", 384'(o_locked), 384'd0);
        check("hdrbad_pkts", 384'(pkt_total - p0), 384'd79);
        p0 = pkt_total; f0 = first_total; pin_en = 1'b1; pin_base = pkt_total;
        send_mf(-1, -1, -1, 0, 0, -1, 0);
        idle(2);
        check("relock_pkts", 384'(pkt_total - p0), 384'(PKT_MF));
        check("relock_first", 384'(first_total - f0), 384'd1);

        // bad stuff on row 2
        p0 = pkt_total; pin_base = pkt_total;
        send_mf(-1, 2, -1, 0, 0, -1, 0);
        idle(2);
        check("stuff_cnt_lit", 384'(o_stuff_err_cnt), 384'd1);
        check("stuff_lock", 384'(o_locked), 384'd1);
        check("stuff_pkts", 384'(pkt_total - p0), 384'(PKT_MF));
        pin_en = 1'b0;

        // stray rs at beat 50 of row 0
        p0 = pkt_total;
        send_mf(-1, -1, 0, 50, 0, -1, 0);
        idle(2);
        check("rs_hdr_cnt", 384'(o_hdr_err_cnt), 384'd2);
        check("rs_lock", 384'(o_locked), 384'd0);
        check("rs_pkts", 384'(pkt_total - p0), 384'd49);

        // reset pulse mid-row, then relock with counters restarted
        send_mf(-1, -1, -1, 0, 0, 1, 30);
        p0 = pkt_total; f0 = first_total;
        send_mf(-1, -1, -1, 0, 0, -1, 0);
        idle(2);
        check("rst_pkts", 384'(pkt_total - p0), 384'(PKT_MF));
        check("rst_first", 384'(first_total - f0), 384'd1);
        check("rst_cnts", 384'({o_hdr_err_cnt, o_stuff_err_cnt}), 384'd0);

        // randomized faults and gaps against the model
        for (int i = 0; i < 4; i++) begin
            salt = $urandom;
            send_mf(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                    int'($urandom_range(1, R - 1)), int'($urandom_range(0, 40)), -1, 0);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/odu_deframer.md
# odu_deframer

Downstream consumer of the ODU row stream produced by the ODU data generator. It locks to the 3-row multiframe using the row-start strobe, the MFAS value and the 128-bit row header. It checks the header and byte-stuff fields, strips them, and re-packs the remaining payload into contiguous 384-bit OSU packets. It feeds the OSU packet checker and reports lock state and error counts for the status block.

## Interface
Parameters:
- ROW_BEATS, 80: beats per row, counting header beat, payload beats and end beat. Legal range 3..127.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_odu_data  in  384  ODU beat.
- i_odu_valid  in  1  beat qualifier; all logic advances only on valid beats.
- i_odu_rs  in  1  row-start; high on the header beat.
- i_odu_mfas  in  8  row tag: 0, 64 or 128 for rows 0, 1 and 2.
- o_osu_data  out  384  recovered OSU packet.
- o_osu_valid  out  1  packet qualifier, one cycle per packet.
- o_osu_first  out  1  first packet of a multiframe; qualified by o_osu_valid.
- o_locked  out  1  frame lock.
- o_row_idx  out  2  current row, 0..2.
- o_hdr_err_cnt  out  16  saturating header/alignment error count.
- o_stuff_err_cnt  out  16  saturating stuff error count.

## Operation
- Segments are 128-bit. Segments are always taken MSB-first.
- Header beat: bits [383:256] are the header; carries 2 payload segments.
- Payload beat: carries 3 payload segments.
- End beat (beat index ROW_BEATS-1): carries 2 payload segments; bits [127:0] are stuff.
- Header pattern per row: row 0 is 0x11 repeated 16 times, row 1 is 0x22×16, row 2 is 0x33×16.
- Stuff pattern: 0x99×16.
- FSM has two states, HUNT and SYNC.
- HUNT:
  - Discard all beats; gearbox is empty.
  - A valid beat with rs=1, mfas=0 and header 0x11×16 moves to SYNC.
  - On that transition: beat_cnt=1, row_idx=0, and the beat's 2 payload segments load the gearbox.
- SYNC, on every valid beat:
  - beat_cnt increments, wrapping to 0 after ROW_BEATS-1.
  - Expected header beat is beat_cnt==0.
- SYNC, header checks. Each of the following increments hdr_err_cnt, returns to HUNT and flushes the gearbox; the offending beat is not re-evaluated for lock:
  - rs=1 when beat_cnt≠0.
  - rs=0 when beat_cnt==0.
  - mfas ≠ 64×row_idx.
  - header ≠ pattern for row_idx.
- SYNC, stuff check: on the end beat, stuff ≠ 0x99×16 increments stuff_err_cnt. Lock and data are unaffected.
- row_idx advances 0→1→2→0 on each accepted header beat.
- Gearbox:
  - Residue holds 0..2 segments. Append the incoming segments.
  - If 3 or more segments are held, emit the oldest 3 as one packet; the oldest segment goes in bits [383:256].
  - At most one packet is emitted per beat.
  - Residue is 0 at every row-0 header (714 segments per multiframe gives 238 packets).
- o_osu_first is set on the first packet whose leading segment came from a row-0 header beat.
- Error counters saturate at 0xFFFF and clear only on reset.

## Timing
- Reset values: all outputs are 0; FSM in HUNT; gearbox, beat_cnt and row_idx are 0.
- Reset mid-stream: outputs are 0 asynchronously; relock requires a fresh row-0 header.
- o_osu_data, o_osu_valid and o_osu_first are registered and appear 1 cycle after the valid beat that completes the packet. o_osu_valid is low otherwise.
- o_locked rises 1 cycle after the locking beat and falls 1 cycle after the failing beat.
- Counters update 1 cycle after the offending beat.
- i_odu_valid low: nothing changes; o_osu_valid is low that cycle.
- Valid gaps of any length must not change the output packet sequence.
- Simultaneous header error and packet completion on the same beat: the packet is not emitted (flush wins).

## Structure
- Shared package odu_pkg holds:
  - header constants for rows 0/1/2;
  - stuff constant 0x99×16;
  - MFAS row values 0/64/128;
  - segment width 128 and beat width 384;
  - deframer state encoding.
- The generator migrates to odu_pkg as well.
- Sub-module osu_gearbox:
  - inputs: segment-count (0, 2 or 3), 384-bit segment bus, flush;
  - outputs: 384-bit packet and valid;
  - contains the 640-bit accumulator and 3-bit fill count.

## Test plan
- Clean 3-row multiframe, payload segments numbered 0..713 -> 238 packets carrying segments in order 0..713; o_osu_first on packet 0 only; both counters 0; o_locked high from cycle 2.
- Two multiframes with random i_odu_valid gaps (50% duty) -> output identical to the gap-free run (476 packets).
- Row-1 header byte 5 corrupted to 0x23 -> hdr_err_cnt=1; o_locked low; no packets until the next row-0 header; output resumes with o_osu_first=1.
- End-beat stuff of row 2 set to 0x98×16 -> stuff_err_cnt=1; o_locked stays high; 238 packets unchanged.
- rs pulsed at beat_cnt=50 -> hdr_err_cnt=1 and lock lost; beats before the next row-0 header are ignored.
- i_rst_n pulsed low for 1 ns mid-row -> all outputs 0 immediately; relock on the next row-0 header; counters restart at 0.
